bldc_pwm_controller: RTL and testbench

- Closed-loop-ready drive sequencer for the BLDC motor interface.
- Accepts duty/direction commands over a valid/ready handshake and generates the motor_positive/motor_negative PWM pair with soft ramping.
- Direction reversals are forced through ramp-down and dead-time.
- Decodes encoder_a/encoder_b quadrature feedback into a signed position count. Sits between the control/host logic and the motor (or the motor emulation model in simulation).

---
 rtl/bldc_pwm_controller.sv | 186 ++++++++++++++++++
 tb/tb_bldc_pwm_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_pwm_controller.sv
// BLDC drive sequencer: command handshake, soft-ramped PWM pair with forced
// ramp-down and dead-time on reversal, and a quadrature position decoder.
module bldc_pwm_controller #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned DEADTIME   = 8,
    parameter int unsigned RAMP_STEP  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_duty,
    input  logic                  cmd_dir,
    output logic                  motor_positive,
    output logic                  motor_negative,
    input  logic                  encoder_a,
    input  logic                  encoder_b,
    output logic [DATA_WIDTH-1:0] position,
    output logic                  enc_error,
    output logic [1:0]            state
);

    localparam logic [DATA_WIDTH-1:0] PeriodW  = DATA_WIDTH'(PWM_PERIOD);
    localparam logic [DATA_WIDTH-1:0] LastCnt  = DATA_WIDTH'(PWM_PERIOD - 1);
    localparam logic [DATA_WIDTH-1:0] StepW    = DATA_WIDTH'(RAMP_STEP);
    localparam int unsigned           DeadW    = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DeadW-1:0]      DeadLast = DeadW'(DEADTIME - 1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StRampDown = 2'd2,
        StDead     = 2'd3
    } state_e;

    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_pwm_cnt;
    logic [DATA_WIDTH-1:0] r_cur_duty;
    logic [DATA_WIDTH-1:0] r_tgt_duty;
    logic [DATA_WIDTH-1:0] r_pend_duty;
    logic                  r_pend_dir;
    logic                  r_cur_dir;
    logic [DeadW-1:0]      r_dead_cnt;
    logic                  r_mot_pos;
    logic                  r_mot_neg;

    logic [1:0]            r_enc_meta;
    logic [1:0]            r_enc_sync;
    logic [1:0]            r_enc_prev;
    logic [DATA_WIDTH-1:0] r_position;
    logic                  r_enc_error;

    logic [DATA_WIDTH-1:0] w_clamped;
    logic [DATA_WIDTH-1:0] w_ramp_next;
    logic                  w_accept;
    logic                  w_boundary;
    logic                  w_drive_on;
    logic                  w_reverse;
    logic                  w_enc_inc;
    logic                  w_enc_dec;
    logic                  w_enc_err;

    assign cmd_ready  = (r_state == StIdle) || (r_state == StRun);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_clamped  = (cmd_duty > PeriodW) ? PeriodW : cmd_duty;
    assign w_boundary = (r_pwm_cnt == LastCnt);
    assign w_drive_on = (r_pwm_cnt < r_cur_duty) && ((r_state == StRun) || (r_state == StRampDown));
    assign w_reverse  = (cmd_dir != r_cur_dir) && (r_cur_duty != '0);

    // One ramp step toward the target, landing exactly on it
    always_comb begin
        w_ramp_next = r_cur_duty;
        if (r_cur_duty < r_tgt_duty) begin
            if ((r_tgt_duty - r_cur_duty) <= StepW) w_ramp_next = r_tgt_duty;
            else                                    w_ramp_next = r_cur_duty + StepW;
        end else if (r_cur_duty > r_tgt_duty) begin
            if ((r_cur_duty - r_tgt_duty) <= StepW) w_ramp_next = r_tgt_duty;
            else                                    w_ramp_next = r_cur_duty - StepW;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_pwm_cnt   <= '0;
            r_cur_duty  <= '0;
            r_tgt_duty  <= '0;
            r_pend_duty <= '0;
            r_pend_dir  <= 1'b1;
            r_cur_dir   <= 1'b1;
            r_dead_cnt  <= '0;
            r_mot_pos   <= 1'b0;
            r_mot_neg   <= 1'b0;
        end else begin
            r_mot_pos <= w_drive_on && r_cur_dir;
            r_mot_neg <= w_drive_on && !r_cur_dir;
            unique case (r_state)
                StIdle: begin
                    r_pwm_cnt <= '0;
                    if (w_accept && (w_clamped != '0)) begin
                        r_cur_dir  <= cmd_dir;
                        r_tgt_duty <= w_clamped;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    r_pwm_cnt <= w_boundary ? '0 : r_pwm_cnt + 1'b1;
                    if (w_boundary) r_cur_duty <= w_ramp_next;
                    if (w_accept && w_reverse) begin
                        r_pend_duty <= w_clamped;
                        r_pend_dir  <= cmd_dir;
                        r_tgt_duty  <= '0;
                        r_state     <= StRampDown;
                    end else if (w_accept) begin
                        // Outputs are low whenever cur_duty is 0, so direction may follow freely
                        r_tgt_duty <= w_clamped;
                        r_cur_dir  <= cmd_dir;
                        if (w_boundary && (w_ramp_next == '0) && (w_clamped == '0))
                            r_state <= StIdle;
                    end else if (w_boundary && (w_ramp_next == '0) && (r_tgt_duty == '0)) begin
                        r_state <= StIdle;
                    end
                end
                StRampDown: begin
                    r_pwm_cnt <= w_boundary ? '0 : r_pwm_cnt + 1'b1;
                    if (w_boundary) begin
                        r_cur_duty <= w_ramp_next;
                        if (w_ramp_next == '0) begin
                            r_dead_cnt <= '0;
                            r_state    <= StDead;
                        end
                    end
                end
                StDead: begin
                    r_pwm_cnt <= '0;
                    if (r_dead_cnt == DeadLast) begin
                        r_cur_dir  <= r_pend_dir;
                        r_tgt_duty <= r_pend_duty;
                        r_state    <= (r_pend_duty != '0) ? StRun : StIdle;
                    end else begin
                        r_dead_cnt <= r_dead_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Pair is {A, B}; forward order is 00 -> 10 -> 11 -> 01 -> 00
    always_comb begin
        w_enc_inc = 1'b0;
        w_enc_dec = 1'b0;
        w_enc_err = 1'b0;
        case ({r_enc_prev, r_enc_sync})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_enc_inc = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_enc_dec = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_enc_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enc_meta  <= '0;
            r_enc_sync  <= '0;
            r_enc_prev  <= '0;
            r_position  <= '0;
            r_enc_error <= 1'b0;
        end else begin
            r_enc_meta <= {encoder_a, encoder_b};
            r_enc_sync <= r_enc_meta;
            r_enc_prev <= r_enc_sync;
            if (w_enc_inc)      r_position <= r_position + 1'b1;
            else if (w_enc_dec) r_position <= r_position - 1'b1;
            if (w_enc_err) r_enc_error <= 1'b1;
        end
    end

    assign motor_positive = r_mot_pos;
    assign motor_negative = r_mot_neg;
    assign position       = r_position;
    assign enc_error      = r_enc_error;
    assign state          = r_state;

endmodule

// File: tb/tb_bldc_pwm_controller.sv
// Self-checking bench for bldc_pwm_controller: pulse widths and encoder counts
// are compared against a ramp/quadrature model built from plain arithmetic.
module tb_bldc_pwm_controller;

    localparam int DW   = 16;
    localparam int PER  = 100;
    localparam int DT   = 8;
    localparam int STEP = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_duty = '0;
    logic          cmd_dir = 1'b1;
    logic          motor_positive;
    logic          motor_negative;
    logic          encoder_a = 1'b0;
    logic          encoder_b = 1'b0;
    logic [DW-1:0] position;
    logic          enc_error;
    logic [1:0]    state;

    bldc_pwm_controller #(
        .DATA_WIDTH(DW),
        .PWM_PERIOD(PER),
        .DEADTIME  (DT),
        .RAMP_STEP (STEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_duty      (cmd_duty),
        .cmd_dir       (cmd_dir),
        .motor_positive(motor_positive),
        .motor_negative(motor_negative),
        .encoder_a     (encoder_a),
        .encoder_b     (encoder_b),
        .position      (position),
        .enc_error     (enc_error),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Pulse-width monitor: records the length of every completed high run
    int q_pos[$];
    int q_neg[$];
    int pos_run = 0, neg_run = 0, both_hi = 0, dead_cycles = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (motor_positive) pos_run++;
                else if (pos_run > 0) begin q_pos.push_back(pos_run); pos_run = 0; end
                if (motor_negative) neg_run++;
                else if (neg_run > 0) begin q_neg.push_back(neg_run); neg_run = 0; end
                if (motor_positive && motor_negative) both_hi++;
                if (state == 2'd3) dead_cycles++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected pulse widths: one ramp step per period until the target, then steady
    int exp_q[$];
    task automatic ramp_expect(input int from, input int to);
        int c;
        exp_q.delete();
        c = from;
        while (c != to) begin
            if (c < to) c = (to - c <= STEP) ? to : c + STEP;
            else        c = (c - to <= STEP) ? to : c - STEP;
            if (c != to && c > 0 && c < PER) exp_q.push_back(c);
        end
        if (to > 0 && to < PER) begin
            exp_q.push_back(to);
            exp_q.push_back(to);
        end
    endtask

    task automatic compare_q(input string tag, input bit neg);
        int got;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (neg) got = (i < q_neg.size()) ? q_neg[i] : 0;
            else     got = (i < q_pos.size()) ? q_pos[i] : 0;
            check_eq($sformatf("%s[%0d]", tag, i), got, exp_q[i]);
        end
    endtask

    task automatic send_cmd(input int duty, input bit dir);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_duty  = duty[DW-1:0];
        cmd_dir   = dir;
        for (int i = 0; i < 3000; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("cmd_accept", ok, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_fall(input bit neg);
        bit ok, prev, cur;
        ok = 1'b0;
        @(negedge clk);
        prev = neg ? motor_negative : motor_positive;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cur = neg ? motor_negative : motor_positive;
            if (prev && !cur) begin ok = 1'b1; break; end
            prev = cur;
        end
        check_eq("wait_fall", ok, 1);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == s) begin ok = 1'b1; break; end
        end
        check_eq($sformatf("reach_state_%0d", s), ok, 1);
    endtask

    // Quadrature model: position index on the Gray cycle, step = index delta mod 4
    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] enc_ab = 2'b00;
    int         pos_model = 0;
    bit         err_model = 1'b0;

    function automatic int gidx(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) if (gray[i] == ab) return i;
        return 0;
    endfunction

    task automatic enc_move(input logic [1:0] ab);
        int d;
        d = (gidx(ab) - gidx(enc_ab) + 4) % 4;
        if (d == 1)      pos_model++;
        else if (d == 3) pos_model--;
        else if (d == 2) err_model = 1'b1;
        enc_ab = ab;
        @(negedge clk);
        encoder_a = ab[1];
        encoder_b = ab[0];
        repeat (5) @(negedge clk);
    endtask

    task automatic enc_step(input bit fwd);
        enc_move(gray[(gidx(enc_ab) + (fwd ? 1 : 3)) % 4]);
    endtask

    int cur_model;
    int d;
    int cnt;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_state", state, 0);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_mpos", motor_positive, 0);
        check_eq("rst_mneg", motor_negative, 0);
        check_eq("rst_position", position, 0);
        check_eq("rst_enc_error", enc_error, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Startup ramp to 50 forward
        send_cmd(50, 1'b1);
        @(negedge clk);
        check_eq("start_state", state, 1);
        repeat (8 * PER) @(negedge clk);
        ramp_expect(0, 50);
        compare_q("start_pos", 1'b0);
        check_eq("start_neg_count", q_neg.size(), 0);

        // Reversal to 30 reverse
        wait_fall(1'b0);
        q_pos.delete();
        q_neg.delete();
        dead_cycles = 0;
        send_cmd(30, 1'b0);
        @(negedge clk);
        check_eq("rev_ready_low", cmd_ready, 0);
        check_eq("rev_state", state, 2);
        wait_state(2'd1, 20 * PER);
        check_eq("rev_dead_cycles", dead_cycles, DT);
        check_eq("rev_ready_back", cmd_ready, 1);
        repeat (5 * PER) @(negedge clk);
        ramp_expect(50, 0);
        compare_q("rev_pos", 1'b0);
        check_eq("rev_pos_count", q_pos.size(), 4);
        ramp_expect(0, 30);
        compare_q("rev_neg", 1'b1);
        cur_model = 30;

        // Random retargets in the reverse direction
        for (int k = 0; k < 3; k++) begin
            d = $urandom_range(1, 99);
            wait_fall(1'b1);
            q_neg.delete();
            send_cmd(d, 1'b0);
            ramp_expect(cur_model, d);
            repeat ((exp_q.size() + 2) * PER) @(negedge clk);
            compare_q($sformatf("rand%0d_d%0d", k, d), 1'b1);
            cur_model = d;
        end

        // Stop
        wait_fall(1'b1);
        q_neg.delete();
        send_cmd(0, 1'b0);
        wait_state(2'd0, 20 * PER);
        ramp_expect(cur_model, 0);
        compare_q("stop_neg", 1'b1);
        cnt = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (motor_positive || motor_negative || state != 2'd0) cnt++;
        end
        check_eq("stop_quiet", cnt, 0);

        // Zero command from IDLE
        send_cmd(0, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("idle_zero_state", state, 0);
        check_eq("idle_zero_mpos", motor_positive, 0);

        // Clamp: 250 saturates at full period, constant high
        q_pos.delete();
        send_cmd(250, 1'b1);
        repeat (13 * PER) @(negedge clk);
        ramp_expect(0, 100);
        compare_q("clamp_pos", 1'b0);
        check_eq("clamp_pos_count", q_pos.size(), 9);
        cnt = 0;
        for (int i = 0; i < 3 * PER; i++) begin
            @(negedge clk);
            if (!motor_positive || motor_negative) cnt++;
        end
        check_eq("clamp_const_high", cnt, 0);

        // Quadrature: 4 forward then 6 reverse
        for (int i = 0; i < 4; i++) enc_step(1'b1);
        check_eq("enc_fwd4", position, pos_model & 32'hFFFF);
        for (int i = 0; i < 6; i++) enc_step(1'b0);
        check_eq("enc_fffe_model", position, pos_model & 32'hFFFF);
        check_eq("enc_fffe", position, 32'hFFFE);
        check_eq("enc_no_err", enc_error, 0);
        enc_step(1'b0);
        enc_step(1'b0);
        check_eq("enc_back_to_00", position, pos_model & 32'hFFFF);
        enc_move(2'b11);
        check_eq("enc_jump_pos", position, pos_model & 32'hFFFF);
        check_eq("enc_jump_err", enc_error, err_model);
        for (int i = 0; i < 16; i++) begin
            enc_step($urandom_range(0, 1) == 1);
            check_eq($sformatf("enc_walk%0d", i), position, pos_model & 32'hFFFF);
        end
        check_eq("enc_err_sticky", enc_error, 1);
        check_eq("never_both_high", both_hi, 0);

        // Async reset while ramping down with the output high
        send_cmd(20, 1'b0);
        @(negedge clk);
        check_eq("ar_state_ramp", state, 2);
        check_eq("ar_mpos_high", motor_positive, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_mpos", motor_positive, 0);
        check_eq("ar_mneg", motor_negative, 0);
        check_eq("ar_state", state, 0);
        check_eq("ar_position", position, 0);
        check_eq("ar_enc_error", enc_error, 0);
        check_eq("ar_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
